// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline registers and PC.
// Ports: clk, reset (sync, active-high); ID/EX hazard sources, branch,
//   mult/div issue/use, data-memory handshake; per-register en/flush,
//   md_busy (registered) and a saturating stall_cycles counter.
module pipe_hazard_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic        ex_br_taken,
    input  logic        id_md_start,
    input  logic        id_md_div,
    input  logic        id_md_use,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYC - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] ld_val;

    logic freeze;
    logic load_use;
    logic md_stall;
    logic stall;
    logic hit_freeze;
    logic hit_branch;
    logic hit_stall;
    logic advance;

    assign md_busy  = (state == BUSY);
    assign freeze   = mem_req & ~mem_ready;
    assign md_stall = md_busy & (id_md_use | id_md_start);
    assign load_use = ex_memread & ex_regwrite & (ex_rd != 5'd0)
                    & ((id_use_rs & (id_rs == ex_rd))
                     | (id_use_rt & (id_rt == ex_rd)));
    assign stall    = md_stall | load_use;

    // Priority folded into mutually exclusive terms
    assign hit_freeze = freeze;
    assign hit_branch = ~freeze & ex_br_taken;
    assign hit_stall  = ~freeze & ~ex_br_taken & stall;
    assign advance    = ~freeze & ~ex_br_taken & ~stall;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        unique case (1'b1)
            hit_freeze: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            hit_branch: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            hit_stall: begin
                // Hold PC and IF/ID, push one bubble into EX
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign ld_val = id_md_div ? DIV_LD : MUL_LD;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                // A single-cycle op never enters BUSY
                if (id_md_start && advance && ld_val != '0) begin
                    state_nxt = BUSY;
                    cnt_nxt   = ld_val;
                end
            end
            BUSY: begin
                // Countdown runs through freezes too
                if (cnt == ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change 1 time unit after posedge; checks follow 1 unit later.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt;
    logic        ex_memread, ex_regwrite, ex_br_taken;
    logic        id_md_start, id_md_div, id_md_use;
    logic        mem_req, mem_ready;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, memwb_en, md_busy;
    logic [31:0] stall_cycles;

    int n_chk = 0;
    int n_err = 0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    logic [6:0] ctl;
    localparam logic [6:0] RUN    = 7'b1101011;
    localparam logic [6:0] STALL  = 7'b0001111;
    localparam logic [6:0] BRANCH = 7'b1111111;
    localparam logic [6:0] FREEZE = 7'b0000000;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                  idex_flush, exmem_en, memwb_en};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_regwrite(ex_regwrite), .ex_br_taken(ex_br_taken),
        .id_md_start(id_md_start), .id_md_div(id_md_div),
        .id_md_use(id_md_use),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_use_rs = 0; id_use_rt = 0;
        ex_memread = 0; ex_regwrite = 0; ex_br_taken = 0;
        id_md_start = 0; id_md_div = 0; id_md_use = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd8;
        id_use_rs = 1; id_rs = 5'd8;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, RUN);
        end
        n_chk++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", md_busy);
        end
        n_chk++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL reset_sc: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        n_chk++;
        if (ctl !== STALL) begin
            n_err++; $display("FAIL lu_rs: got %b want %b", ctl, STALL);
        end
        tick();
        clear_inputs();
        #1;
        n_chk++;
        if (stall_cycles !== 32'd1) begin
            n_err++; $display("FAIL lu_sc: got %0d want 1", stall_cycles);
        end
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL lu_after: got %b want %b", ctl, RUN);
        end
        // rt operand match
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd17;
        id_use_rt = 1; id_rt = 5'd17; id_rs = 5'd3;
        #1;
        n_chk++;
        if (ctl !== STALL) begin
            n_err++; $display("FAIL lu_rt: got %b want %b", ctl, STALL);
        end
        // match but operand not read
        id_use_rt = 0;
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL lu_nouse: got %b want %b", ctl, RUN);
        end
        // not a load
        id_use_rt = 1; ex_memread = 0;
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL lu_noload: got %b want %b", ctl, RUN);
        end
        // load that does not write
        ex_memread = 1; ex_regwrite = 0;
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL lu_nowr: got %b want %b", ctl, RUN);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rd0();
        do_reset();
        set_load_use();
        ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL rd0_ctl: got %b want %b", ctl, RUN);
        end
        tick();
        clear_inputs();
        n_chk++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL rd0_sc: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use();
        ex_br_taken = 1;
        id_md_start = 1;
        #1;
        n_chk++;
        if (ctl !== BRANCH) begin
            n_err++; $display("FAIL br_ctl: got %b want %b", ctl, BRANCH);
        end
        tick();
        clear_inputs();
        n_chk++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL br_sc: got %0d want 0", stall_cycles);
        end
        n_chk++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL br_nostart: got %b want 0", md_busy);
        end
    endtask

    task automatic test_mult();
        do_reset();
        id_md_start = 1; id_md_div = 0;
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL mul_issue: got %b want %b", ctl, RUN);
        end
        tick();
        id_md_start = 0; id_md_use = 1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_chk++;
            if (md_busy !== 1'b1 || ctl !== STALL) begin
                n_err++;
                $display("FAIL mul_busy c%0d: got busy=%b ctl=%b want busy=1 ctl=%b",
                         c, md_busy, ctl, STALL);
            end
            tick();
        end
        #1;
        n_chk++;
        if (md_busy !== 1'b0 || ctl !== RUN) begin
            n_err++;
            $display("FAIL mul_done: got busy=%b ctl=%b want busy=0 ctl=%b",
                     md_busy, ctl, RUN);
        end
        n_chk++;
        if (stall_cycles !== 32'd4) begin
            n_err++; $display("FAIL mul_sc: got %0d want 4", stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_freeze_div();
        do_reset();
        id_md_start = 1; id_md_div = 1;
        tick();
        clear_inputs();
        for (int c = 1; c <= 3; c++) begin
            mem_req = 1; mem_ready = 0;
            ex_br_taken = (c == 2);
            #1;
            n_chk++;
            if (ctl !== FREEZE || md_busy !== 1'b1) begin
                n_err++;
                $display("FAIL frz c%0d: got ctl=%b busy=%b want ctl=%b busy=1",
                         c, ctl, md_busy, FREEZE);
            end
            tick();
        end
        clear_inputs();
        // completed memory access is not a freeze
        mem_req = 1; mem_ready = 1;
        #1;
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL frz_ready: got %b want %b", ctl, RUN);
        end
        // a second MD op while busy stalls
        id_md_start = 1;
        #1;
        n_chk++;
        if (ctl !== STALL) begin
            n_err++; $display("FAIL md_restart: got %b want %b", ctl, STALL);
        end
        tick();
        clear_inputs();
        for (int c = 5; c <= 9; c++) begin
            #1;
            n_chk++;
            if (md_busy !== 1'b1) begin
                n_err++; $display("FAIL div_busy c%0d: got %b want 1", c, md_busy);
            end
            tick();
        end
        n_chk++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL div_done: got %b want 0", md_busy);
        end
        n_chk++;
        if (stall_cycles !== 32'd4) begin
            n_err++; $display("FAIL frz_sc: got %0d want 4", stall_cycles);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        id_md_start = 1; id_md_div = 1;
        tick();
        id_md_start = 0; id_md_use = 1;
        tick();
        tick();
        #1;
        n_chk++;
        if (md_busy !== 1'b1 || stall_cycles !== 32'd2) begin
            n_err++;
            $display("FAIL rst_pre: got busy=%b sc=%0d want busy=1 sc=2",
                     md_busy, stall_cycles);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_chk++;
        if (md_busy !== 1'b0 || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid: got busy=%b sc=%0d want busy=0 sc=0",
                     md_busy, stall_cycles);
        end
        n_chk++;
        if (ctl !== RUN) begin
            n_err++; $display("FAIL rst_use: got %b want %b", ctl, RUN);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_rd0();
        test_branch();
        test_mult();
        test_freeze_div();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards, squashes the wrong path on taken branches, and freezes the pipe on data-memory wait.
- Tracks the multi-cycle mult/div unit with an internal busy FSM.
- Drives per-register enable and flush lines. Flush means the register loads a NOP bubble on that edge.

Parameters:
- MUL_CYC, 5, total cycles a mult occupies the MD unit (>=1)
- DIV_CYC, 10, total cycles a div occupies the MD unit (>=1)
- CNT_W, 4, MD countdown width; must hold max(MUL_CYC,DIV_CYC)-1

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_regwrite  in  1  EX instruction writes the register file
- ex_br_taken  in  1  branch/jump in EX resolved taken
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_div  in  1  qualifies id_md_start: 1=div, 0=mult
- id_md_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID load bubble
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX load bubble
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- md_busy  out  1  MD unit busy (registered)
- stall_cycles  out  32  count of cycles with pc_en=0 (registered, saturating)

Behaviour:
- Reset (reset=1 at a rising edge): MD FSM -> IDLE, md_cnt -> 0, md_busy -> 0, stall_cycles -> 0.
- Enable/flush outputs are combinational from inputs and state. With state at reset values and no hazard inputs: all en=1, all flush=0.
- Default with no hazard: all en=1, all flush=0.
- Hazard conditions are evaluated in this priority order; the first one that matches sets the outputs:
  1. FREEZE: mem_req & ~mem_ready. All en=0, all flush=0. Branch flush and stalls are suppressed; the EX branch re-resolves after the freeze.
  2. BRANCH: ex_br_taken. pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=memwb_en=1. Overrides any ID stall, because the ID instruction is squashed.
  3. MD stall: md_busy & (id_md_use | id_md_start).
  4. LOAD-USE: ex_memread & ex_regwrite & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Stall response (MD stall or LOAD-USE): pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1. This inserts exactly one bubble per stalled cycle.
- Load-use stalls last exactly 1 cycle, since the load then leaves EX.
- MD FSM, states IDLE and BUSY:
  - IDLE -> BUSY when id_md_start=1 and the ID instruction advances this cycle (no FREEZE, no BRANCH, no stall).
  - On that transition, md_cnt loads MUL_CYC-1 or DIV_CYC-1 according to id_md_div.
  - If the loaded value is 0, the FSM stays IDLE and md_busy stays 0.
  - BUSY: md_cnt decrements every cycle, including during FREEZE. When md_cnt==1 at the edge, the next state is IDLE with md_cnt=0.
  - md_busy = (state==BUSY). An MD op therefore blocks dependent ID instructions for exactly N-1 cycles after issue.
  - A start squashed by BRANCH or a stall does not launch the FSM.
- stall_cycles: increments by 1 on each edge where pc_en=0 (FREEZE or stall). Holds at 0xFFFFFFFF once reached.
- Reset asserted mid-operation (BUSY or frozen) aborts everything at the next edge; there is no recovery state.

Test Plan:
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=8, id_use_rs=1, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cycles 0->1.
- rd=0 guard: same as above but ex_rd=0, id_rs=0 -> no stall, all en=1, flush=0.
- Branch over load-use: load-use condition plus ex_br_taken=1 -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cycles unchanged.
- Mult then mfhi: id_md_start=1, id_md_div=0 in cycle 0, then id_md_use=1 held -> md_busy=1 in cycles 1-4 with pc_en=0 in those cycles, md_busy=0 and pc_en=1 in cycle 5; stall_cycles=4.
- Freeze during div: issue div, then mem_req=1, mem_ready=0 for 3 cycles -> all en=0, flush=0; md_busy falls 9 cycles after issue regardless of the freeze.
- Reset mid-BUSY: reset=1 for one edge during a div -> md_busy=0, stall_cycles=0 next cycle; a pending id_md_use no longer stalls.
